clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 32 +++
 rtl/clk_div_ctrl_if.sv | 50 +++++
 rtl/clk_div_phase_cnt.sv | 39 +++
 rtl/clk_div_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the clock-divider control slice: FSM state encoding,
// default ratio width and the ratio driven out of reset, plus small helpers
// that classify states.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int RATIO_WIDTH_DEF = 4;
  localparam int RESET_RATIO_DEF = 4;

  // Wide enough for the 1..7 settle-length range.
  localparam int SETTLE_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // States in which the downstream divider is clocked.
  function automatic logic state_has_clk(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

  // States in which a new ratio request can be taken.
  function automatic logic state_takes_req(input state_t s);
    return (s == ST_OFF) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Request/enable bundle between a requester (master) and clk_div_ctrl (slave).
//   i_enable     master->slave  level request to run the divider
//   i_req_valid  master->slave  ratio-change request valid
//   i_req_ratio  master->slave  requested divide ratio
//   o_req_ready  slave->master  request taken when valid && ready
//   o_div_ratio  slave->master  ratio presented to the clock divider
//   o_clk_en     slave->master  enable to the clock divider
//   o_done       slave->master  one-cycle pulse: accepted ratio in effect
//   o_err        slave->master  one-cycle pulse: request rejected
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) ();

  logic                   i_enable;
  logic                   i_req_valid;
  logic [RATIO_WIDTH-1:0] i_req_ratio;
  logic                   o_req_ready;
  logic [RATIO_WIDTH-1:0] o_div_ratio;
  logic                   o_clk_en;
  logic                   o_done;
  logic                   o_err;

  modport master (
    output i_enable,
    output i_req_valid,
    output i_req_ratio,
    input  o_req_ready,
    input  o_div_ratio,
    input  o_clk_en,
    input  o_done,
    input  o_err
  );

  modport slave (
    input  i_enable,
    input  i_req_valid,
    input  i_req_ratio,
    output o_req_ready,
    output o_div_ratio,
    output o_clk_en,
    output o_done,
    output o_err
  );

endinterface

// File: rtl/clk_div_phase_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_phase_cnt
// Tracks the divider phase 0..ratio-1 while the divider is enabled and flags
// the last phase of each period.
//   i_ref_clk  in   reference clock (rising edge)
//   i_rst      in   asynchronous active-high reset, phase -> 0
//   load       in   restart the count at phase 0 on the next edge
//   enable     in   advance the phase this cycle
//   ratio      in   current divide ratio (nonzero, stable while enabled)
//   boundary   out  phase == ratio-1 (every cycle when ratio is 1)
// -----------------------------------------------------------------------------
module clk_div_phase_cnt
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   load,
  input  logic                   enable,
  input  logic [RATIO_WIDTH-1:0] ratio,
  output logic                   boundary
);

  logic [RATIO_WIDTH-1:0] phase_q;

  assign boundary = (phase_q == (ratio - RATIO_WIDTH'(1)));

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= '0;
    end else if (load) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= boundary ? '0 : (phase_q + RATIO_WIDTH'(1));
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Controls an external clock divider: hands it a divide ratio and an enable,
// and changes the ratio only with the divider stopped. A ratio change waits
// for the end of the current divider period (DRAIN), swaps the ratio with
// the enable low, holds off for SETTLE_CYCLES (SETTLE), then resumes.
//
// Ports:
//   i_ref_clk  in   reference clock, all logic on its rising edge
//   i_rst      in   asynchronous active-high reset
//   bus        slave modport of clk_div_ctrl_if (enable, ratio request
//              handshake, ratio/enable to the divider, done/err pulses)
//
// Parameters:
//   RATIO_WIDTH    width of the divide ratio
//   RESET_RATIO    ratio driven after reset
//   SETTLE_CYCLES  cycles the enable stays low around a ratio change (1..7)
//
// Build option:
//   CLK_DIV_CTRL_EVEN_ONLY_EN  when defined, odd ratios above 1 are rejected
//                              like ratio 0; otherwise any nonzero ratio is
//                              accepted.
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH   = RATIO_WIDTH_DEF,
  parameter int RESET_RATIO   = RESET_RATIO_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         i_ref_clk,
  input  logic         i_rst,
  clk_div_ctrl_if.slave bus
);

  state_t                  state_q, state_d;
  logic [RATIO_WIDTH-1:0]  ratio_q, ratio_d;
  logic [RATIO_WIDTH-1:0]  pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic                    clk_en_q, clk_en_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    phase_load;
  logic                    boundary;
  logic                    req_take;
  logic                    req_good;

  function automatic logic ratio_ok(input logic [RATIO_WIDTH-1:0] r);
`ifdef CLK_DIV_CTRL_EVEN_ONLY_EN
    return (r != '0) && ((r == RATIO_WIDTH'(1)) || !r[0]);
`else
    return (r != '0);
`endif
  endfunction

  assign req_take = bus.i_req_valid && ready_q;
  assign req_good = ratio_ok(bus.i_req_ratio);

  clk_div_phase_cnt #(
    .RATIO_WIDTH (RATIO_WIDTH)
  ) u_phase_cnt (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .load      (phase_load),
    .enable    (clk_en_q),
    .ratio     (ratio_q),
    .boundary  (boundary)
  );

  always_comb begin
    state_d    = state_q;
    ratio_d    = ratio_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    phase_load = 1'b0;

    case (state_q)
      ST_OFF: begin
        // A request in the same cycle as enable wins; the enable is seen
        // again on a later cycle.
        if (req_take && req_good) begin
          ratio_d = bus.i_req_ratio;
          done_d  = 1'b1;
        end else if (req_take) begin
          err_d = 1'b1;
        end else if (bus.i_enable) begin
          state_d    = ST_RUN;
          phase_load = 1'b1;
        end
      end

      ST_RUN: begin
        // A rejected request leaves the state alone even if enable fell;
        // the fall is acted on the following cycle.
        if (req_take && req_good) begin
          pend_d     = bus.i_req_ratio;
          pend_vld_d = 1'b1;
          state_d    = ST_DRAIN;
        end else if (req_take) begin
          err_d = 1'b1;
        end else if (!bus.i_enable) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (boundary) begin
          if (pend_vld_q) begin
            ratio_d    = pend_q;
            pend_vld_d = 1'b0;
            settle_d   = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
            state_d    = ST_SETTLE;
          end else begin
            state_d = ST_OFF;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          done_d = 1'b1;
          if (bus.i_enable) begin
            state_d    = ST_RUN;
            phase_load = 1'b1;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          settle_d = settle_q - SETTLE_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    clk_en_d = state_has_clk(state_d);
    ready_d  = state_takes_req(state_d);
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_OFF;
      ratio_q    <= RATIO_WIDTH'(RESET_RATIO);
      pend_vld_q <= 1'b0;
      settle_q   <= '0;
      clk_en_q   <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ratio_q    <= ratio_d;
      pend_vld_q <= pend_vld_d;
      settle_q   <= settle_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Pending ratio payload is qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge i_ref_clk) begin
    pend_q <= pend_d;
  end

  assign bus.o_div_ratio = ratio_q;
  assign bus.o_clk_en    = clk_en_q;
  assign bus.o_req_ready = ready_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

  a_done_err_excl : assert property (
    @(posedge i_ref_clk) disable iff (i_rst) !(done_q && err_q));

  a_ratio_frozen : assert property (
    @(posedge i_ref_clk) disable iff (i_rst) clk_en_q |-> $stable(ratio_q));

  a_no_ready_pending : assert property (
    @(posedge i_ref_clk) disable iff (i_rst) pend_vld_q |-> !ready_q);

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  localparam int RW      = 4;
  localparam int RST_R   = 4;
  localparam int SETTLE  = 2;

  logic clk = 1'b0;
  logic rst;

  clk_div_ctrl_if #(.RATIO_WIDTH(RW)) bus ();

  clk_div_ctrl #(
    .RATIO_WIDTH   (RW),
    .RESET_RATIO   (RST_R),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The divider is described by what it is doing (running, draining to the
  // end of a period, or holding off) and by how many enabled cycles have
  // elapsed since it started; the phase is that count modulo the ratio.
  int m_ratio;
  int m_pend;      // -1: none
  bit m_run;
  bit m_drain;
  int m_settle;    // holdoff cycles still to go
  int m_t;         // enabled cycles since the divider started
  bit m_done;
  bit m_err;

  function automatic bit m_ok(input int r);
`ifdef CLK_DIV_CTRL_EVEN_ONLY_EN
    return (r != 0) && (r == 1 || (r % 2) == 0);
`else
    return r != 0;
`endif
  endfunction

  function automatic bit m_ready();
    return !m_drain && (m_settle == 0);
  endfunction

  function automatic void m_reset();
    m_ratio = RST_R; m_pend = -1; m_run = 0; m_drain = 0;
    m_settle = 0; m_t = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void m_step(input bit en, input bit v, input int r);
    bit acc;
    acc = v && m_ready();
    m_done = 0;
    m_err  = 0;
    if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin
        m_done = 1;
        if (en) begin m_run = 1; m_t = 0; end
      end
    end else if (m_drain) begin
      if ((m_t % m_ratio) == m_ratio - 1) begin
        m_drain = 0;
        if (m_pend >= 0) begin
          m_ratio = m_pend; m_pend = -1; m_settle = SETTLE;
        end
      end else begin
        m_t++;
      end
    end else if (m_run) begin
      m_t++;
      if (acc && m_ok(r)) begin
        m_pend = r; m_run = 0; m_drain = 1;
      end else if (acc) begin
        m_err = 1;
      end else if (!en) begin
        m_run = 0; m_drain = 1;
      end
    end else begin
      if (acc && m_ok(r)) begin
        m_ratio = r; m_done = 1;
      end else if (acc) begin
        m_err = 1;
      end else if (en) begin
        m_run = 1; m_t = 0;
      end
    end
  endfunction

  // Per-cycle compare against the model.
  initial begin : compare
    bit s_rst, s_en, s_v;
    int s_r;
    m_reset();
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_en  = bus.i_enable;
      s_v   = bus.i_req_valid;
      s_r   = int'(bus.i_req_ratio);
      #1;
      if (s_rst) m_reset();
      else       m_step(s_en, s_v, s_r);
      check("cyc_ready",  32'(bus.o_req_ready), 32'(m_ready()));
      check("cyc_ratio",  32'(bus.o_div_ratio), 32'(m_ratio));
      check("cyc_clk_en", 32'(bus.o_clk_en),    32'(m_run || m_drain));
      check("cyc_done",   32'(bus.o_done),      32'(m_done));
      check("cyc_err",    32'(bus.o_err),       32'(m_err));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin : stim
    rst             = 1'b1;
    bus.i_enable    = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_req_ratio = '0;

    @(negedge clk);
    check("rst_ready",  32'(bus.o_req_ready), 1);
    check("rst_ratio",  32'(bus.o_div_ratio), 4);
    check("rst_clk_en", 32'(bus.o_clk_en),    0);
    check("rst_done",   32'(bus.o_done),      0);
    check("rst_err",    32'(bus.o_err),       0);
    rst = 1'b0;

    @(negedge clk);
    check("off_clk_en", 32'(bus.o_clk_en), 0);
    bus.i_enable = 1'b1;

    // Enable seen: divider runs one cycle later at ratio 4, phase 0.
    @(negedge clk);
    check("en_clk_en", 32'(bus.o_clk_en),    1);
    check("en_ratio",  32'(bus.o_div_ratio), 4);
    bus.i_req_valid = 1'b1; bus.i_req_ratio = 4'd0;

    // Ratio 0 rejected; now at phase 1, request 6.
    @(negedge clk);
    check("zero_err",    32'(bus.o_err),       1);
    check("zero_done",   32'(bus.o_done),      0);
    check("zero_clk_en", 32'(bus.o_clk_en),    1);
    check("zero_ratio",  32'(bus.o_div_ratio), 4);
    check("zero_ready",  32'(bus.o_req_ready), 1);
    bus.i_req_ratio = 4'd6;

    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check("r6_ready",  32'(bus.o_req_ready), 0);
    check("r6_clk_en", 32'(bus.o_clk_en),    1);
    check("r6_ratio",  32'(bus.o_div_ratio), 4);

    @(negedge clk);
    check("r6_ph3_clk_en", 32'(bus.o_clk_en), 1);

    @(negedge clk);
    check("r6_fall_clk_en", 32'(bus.o_clk_en),    0);
    check("r6_fall_ratio",  32'(bus.o_div_ratio), 6);

    @(negedge clk);
    check("r6_settle_clk_en", 32'(bus.o_clk_en), 0);
    check("r6_settle_done",   32'(bus.o_done),   0);

    @(negedge clk);
    check("r6_rise_clk_en", 32'(bus.o_clk_en),    1);
    check("r6_rise_done",   32'(bus.o_done),      1);
    check("r6_rise_ratio",  32'(bus.o_div_ratio), 6);
    bus.i_enable = 1'b0;

    // Drain a full ratio-6 period to OFF.
    repeat (8) @(negedge clk);
    check("stop_clk_en", 32'(bus.o_clk_en),    0);
    check("stop_ready",  32'(bus.o_req_ready), 1);
    check("stop_ratio",  32'(bus.o_div_ratio), 6);

    // Odd ratio in OFF.
    bus.i_req_valid = 1'b1; bus.i_req_ratio = 4'd5;
    @(negedge clk);
`ifdef CLK_DIV_CTRL_EVEN_ONLY_EN
    check("odd5_err",   32'(bus.o_err),       1);
    check("odd5_done",  32'(bus.o_done),      0);
    check("odd5_ratio", 32'(bus.o_div_ratio), 6);
`else
    check("odd5_err",   32'(bus.o_err),       0);
    check("odd5_done",  32'(bus.o_done),      1);
    check("odd5_ratio", 32'(bus.o_div_ratio), 5);
`endif
    bus.i_req_ratio = 4'd8;
    @(negedge clk);
    check("even8_done",  32'(bus.o_done),      1);
    check("even8_err",   32'(bus.o_err),       0);
    check("even8_ratio", 32'(bus.o_div_ratio), 8);

    // Load ratio 1 in OFF, then run.
    bus.i_req_ratio = 4'd1;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check("r1_done",  32'(bus.o_done),      1);
    check("r1_ratio", 32'(bus.o_div_ratio), 1);
    bus.i_enable = 1'b1;

    @(negedge clk);
    check("r1_clk_en", 32'(bus.o_clk_en), 1);
    // Enable falls together with a request for ratio 2.
    bus.i_enable = 1'b0; bus.i_req_valid = 1'b1; bus.i_req_ratio = 4'd2;

    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check("r2_take_clk_en", 32'(bus.o_clk_en),    1);
    check("r2_take_ready",  32'(bus.o_req_ready), 0);

    @(negedge clk);
    check("r2_fall_clk_en", 32'(bus.o_clk_en),    0);
    check("r2_fall_ratio",  32'(bus.o_div_ratio), 2);
    check("r2_fall_done",   32'(bus.o_done),      0);

    @(negedge clk);
    check("r2_settle_clk_en", 32'(bus.o_clk_en), 0);
    check("r2_settle_done",   32'(bus.o_done),   0);

    @(negedge clk);
    check("r2_off_done",   32'(bus.o_done),      1);
    check("r2_off_clk_en", 32'(bus.o_clk_en),    0);
    check("r2_off_ratio",  32'(bus.o_div_ratio), 2);
    check("r2_off_ready",  32'(bus.o_req_ready), 1);

    @(negedge clk);
    check("r2_off_done_pulse", 32'(bus.o_done), 0);
    bus.i_enable = 1'b1;

    // Run at ratio 2, request 6, reset while settling.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_req_ratio = 4'd6;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_clk_en", 32'(bus.o_clk_en),    0);
    check("pre_rst_ratio",  32'(bus.o_div_ratio), 6);
    bus.i_enable = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_ratio",  32'(bus.o_div_ratio), 4);
    check("async_rst_clk_en", 32'(bus.o_clk_en),    0);
    check("async_rst_ready",  32'(bus.o_req_ready), 1);
    check("async_rst_done",   32'(bus.o_done),      0);
    check("async_rst_err",    32'(bus.o_err),       0);

    @(negedge clk);
    rst = 1'b0;
    check("post_rst_done", 32'(bus.o_done), 0);
    repeat (4) @(negedge clk);
    check("post_rst_idle_done",   32'(bus.o_done),      0);
    check("post_rst_idle_clk_en", 32'(bus.o_clk_en),    0);
    check("post_rst_idle_ratio",  32'(bus.o_div_ratio), 4);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
